// File: rtl/bcd_display_driver_pkg.sv
// Shared types and segment constants for the BCD display driver.
// Segment patterns are active-low, bit 6..0 = g..a.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/bcd_display_driver_if.sv
// Load handshake between the value producer and the display driver.
interface bcd_display_driver_if #(
    parameter int DATA_W = 20
);
    logic [DATA_W-1:0] in_value;
    logic              in_mode;
    logic              in_blank_lz;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_value, in_mode, in_blank_lz, in_valid,
        input  in_ready
    );

    modport slave (
        input  in_value, in_mode, in_blank_lz, in_valid,
        output in_ready
    );
endinterface

// File: rtl/bcd_display_driver_seg7_digit.sv
// Combinational 4-bit to 7-segment decoder covering 0-F.
module seg7_digit
    import bcd_display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_LUT[i_nib];
endmodule

// File: rtl/bcd_display_driver.sv
// Multi-digit 7-segment driver: binary in, decimal (double dabble) or hex out.
// Display registers only change on the DONE edge.
module bcd_display_driver
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    bcd_display_driver_if.slave        bus,
    output logic [NUM_DIGITS-1:0][6:0] hex_out,
    output logic                       overflow,
    output logic                       done
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e r_state;
    state_e w_next;

    logic [DATA_W-1:0]          r_val;
    logic [BCD_W-1:0]           r_bcd;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_mode;
    logic                       r_blz;
    logic                       r_ovf;
    logic [NUM_DIGITS-1:0][6:0] r_hex;
    logic                       r_overflow;
    logic                       r_done;

    logic [BCD_W-1:0]           w_adj;
    logic [EXT_W-1:0]           w_ext;
    logic [BCD_W-1:0]           w_digits;
    logic                       w_fin_ovf;
    logic [NUM_DIGITS-1:0][6:0] w_seg;
    logic [NUM_DIGITS-1:0][6:0] w_disp;
    logic                       w_zero_above;
    logic                       w_accept;

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    // Add-3 is per digit and never carries into the next digit
    always_comb begin
        w_adj = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            else
                w_adj[4*d +: 4] = r_bcd[4*d +: 4];
        end
    end

    assign w_ext     = EXT_W'(r_val);
    assign w_digits  = r_mode ? w_ext[BCD_W-1:0] : r_bcd;
    assign w_fin_ovf = r_mode ? |(w_ext >> BCD_W) : r_ovf;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        seg7_digit u_seg (
            .i_nib (w_digits[4*g +: 4]),
            .o_seg (w_seg[g])
        );
    end

    // Scan from the top: a digit blanks if it and everything above is zero
    always_comb begin
        w_disp       = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (w_digits[4*i +: 4] == 4'd0);
            if (w_fin_ovf)
                w_disp[i] = SEG_DASH;
            else if (r_blz && w_zero_above && (i != 0))
                w_disp[i] = SEG_BLANK;
            else
                w_disp[i] = w_seg[i];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid)
                    w_next = bus.in_mode ? DONE : CONV;
            end
            CONV: begin
                if (r_cnt == '0)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_val      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_blz      <= 1'b0;
            r_ovf      <= 1'b0;
            r_hex      <= {NUM_DIGITS{SEG_BLANK}};
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_val  <= bus.in_value;
                r_mode <= bus.in_mode;
                r_blz  <= bus.in_blank_lz;
                r_bcd  <= '0;
                r_ovf  <= 1'b0;
                r_cnt  <= CNT_W'(DATA_W - 1);
            end else if (r_state == CONV) begin
                r_bcd <= {w_adj[BCD_W-2:0], r_val[DATA_W-1]};
                r_ovf <= r_ovf | w_adj[BCD_W-1];
                r_val <= r_val << 1;
                r_cnt <= r_cnt - 1'b1;
            end else if (r_state == DONE) begin
                r_hex      <= w_disp;
                r_overflow <= w_fin_ovf;
            end
        end
    end

    assign bus.in_ready = (r_state == IDLE);
    assign hex_out      = r_hex;
    assign overflow     = r_overflow;
    assign done         = r_done;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench: two driver instances (6x20 and 2x7) against a decimal/hex reference model.
module tb_bcd_display_driver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bcd_display_driver_if #(.DATA_W(20)) ifa ();
    bcd_display_driver_if #(.DATA_W(7))  ifb ();

    logic [5:0][6:0] hexa;
    logic            ovfa, donea;
    logic [1:0][6:0] hexb;
    logic            ovfb, doneb;

    bcd_display_driver #(.NUM_DIGITS(6), .DATA_W(20)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa),
        .hex_out(hexa), .overflow(ovfa), .done(donea)
    );

    bcd_display_driver #(.NUM_DIGITS(2), .DATA_W(7)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb),
        .hex_out(hexb), .overflow(ovfb), .done(doneb)
    );

    typedef struct {
        logic [55:0] seg;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ndone_a = 0;

    function automatic logic [6:0] tseg(input int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic exp_t model(input int nd, input int dw,
                                   input longint unsigned v,
                                   input bit mode, input bit blz,
                                   input int acc);
        exp_t e;
        longint unsigned base, lim, p;
        int dg[8];
        int msd;
        base = mode ? 16 : 10;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * base;
        e.ovf = (v >= lim);
        p = 1;
        msd = 0;
        for (int i = 0; i < 8; i++) begin
            dg[i] = int'((v / p) % base);
            p = p * base;
            if (i < nd && dg[i] != 0) msd = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (i >= nd)
                e.seg[7*i +: 7] = 7'b1111111;
            else if (e.ovf)
                e.seg[7*i +: 7] = 7'b0111111;
            else if (blz && i > msd)
                e.seg[7*i +: 7] = 7'b1111111;
            else
                e.seg[7*i +: 7] = tseg(dg[i]);
        end
        e.acc = acc;
        e.lat = mode ? 1 : dw + 1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected responses enter the scoreboard on the accepting edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ifa.in_valid && ifa.in_ready)
                qa.push_back(model(6, 20, 64'(ifa.in_value),
                    ifa.in_mode, ifa.in_blank_lz, cyc));
            if (ifb.in_valid && ifb.in_ready)
                qb.push_back(model(2, 7, 64'(ifb.in_value),
                    ifb.in_mode, ifb.in_blank_lz, cyc));
        end
    end

    always @(negedge clk) begin
        if (reset_n && donea) begin
            ndone_a++;
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_spurious_done: got done=1 want no pending load");
            end else begin
                ea = qa.pop_front();
                chk("a_seg", 64'({14'h3FFF, hexa}), 64'(ea.seg));
                chk("a_ovf", 64'(ovfa), 64'(ea.ovf));
                chk("a_lat", 64'(cyc - ea.acc), 64'(ea.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && doneb) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_spurious_done: got done=1 want no pending load");
            end else begin
                eb = qb.pop_front();
                chk("b_seg", 64'({{42{1'b1}}, hexb}), 64'(eb.seg));
                chk("b_ovf", 64'(ovfb), 64'(eb.ovf));
                chk("b_lat", 64'(cyc - eb.acc), 64'(eb.lat));
            end
        end
    end

    task automatic load_a(input logic [19:0] v, input bit m, input bit b,
                          input bit keep, output int acc);
        int n;
        @(negedge clk);
        ifa.in_value = v;
        ifa.in_mode = m;
        ifa.in_blank_lz = b;
        ifa.in_valid = 1'b1;
        n = 0;
        while (!ifa.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifa.in_ready) begin
            total++;
            bad++;
            $display("FAIL a_accept_timeout: got in_ready=0 want 1");
            ifa.in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        if (!keep) ifa.in_valid = 1'b0;
    endtask

    task automatic load_b(input logic [6:0] v, input bit m, input bit b);
        int n;
        @(negedge clk);
        ifb.in_value = v;
        ifb.in_mode = m;
        ifb.in_blank_lz = b;
        ifb.in_valid = 1'b1;
        n = 0;
        while (!ifb.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifb.in_ready) begin
            total++;
            bad++;
            $display("FAIL b_accept_timeout: got in_ready=0 want 1");
        end else begin
            @(negedge clk);
        end
        ifb.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0",
                     qa.size() + qb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    int acc5, acc9, accr, nd0;
    logic [19:0] rv;

    initial begin
        ifa.in_value = '0; ifa.in_mode = 0; ifa.in_blank_lz = 0; ifa.in_valid = 0;
        ifb.in_value = '0; ifb.in_mode = 0; ifb.in_blank_lz = 0; ifb.in_valid = 0;
        repeat (3) @(negedge clk);
        chk("rst_hex_a", 64'(hexa), 64'({6{7'b1111111}}));
        chk("rst_hex_b", 64'(hexb), 64'({2{7'b1111111}}));
        chk("rst_ovf_a", 64'(ovfa), 64'(0));
        chk("rst_done_a", 64'(donea), 64'(0));
        chk("rst_ready_a", 64'(ifa.in_ready), 64'(1));
        reset_n = 1'b1;

        load_a(20'd123456, 0, 0, 0, acc5); drain();
        chk("d123456", 64'(hexa), 64'({7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010}));
        load_a(20'd42, 0, 1, 0, acc5); drain();
        chk("d42_blz", 64'(hexa), 64'({{4{7'b1111111}}, 7'b0011001, 7'b0100100}));
        load_a(20'd0, 0, 1, 0, acc5); drain();
        chk("d0_blz", 64'(hexa), 64'({{5{7'b1111111}}, 7'b1000000}));
        load_a(20'd1000000, 0, 0, 0, acc5); drain();
        chk("d1e6_dash", 64'(hexa), 64'({6{7'b0111111}}));
        chk("d1e6_ovf", 64'(ovfa), 64'(1));
        load_a(20'd7, 0, 0, 0, acc5); drain();
        chk("d7_ovf_clr", 64'(ovfa), 64'(0));
        chk("d7_hex0", 64'(hexa[0]), 64'(7'b1111000));
        load_a(20'hABCDE, 1, 0, 0, acc5); drain();
        chk("hABCDE", 64'(hexa), 64'({7'b1000000, 7'b0001000, 7'b0000011,
                                      7'b1000110, 7'b0100001, 7'b0000110}));

        load_a(20'd5, 0, 0, 1, acc5);
        load_a(20'd9, 0, 0, 0, acc9);
        drain();
        chk("busy_b2b_edge", 64'(acc9 - acc5), 64'(22));
        chk("busy_shows9", 64'(hexa[0]), 64'(7'b0010000));

        load_b(7'd99, 0, 0); drain();
        chk("b99", 64'(hexb), 64'({7'b0010000, 7'b0010000}));
        load_b(7'd100, 0, 0); drain();
        chk("b100_dash", 64'(hexb), 64'({2{7'b0111111}}));
        chk("b100_ovf", 64'(ovfb), 64'(1));

        for (int i = 0; i < 40; i++) begin
            case ($urandom % 4)
                0: rv = 20'($urandom);
                1: rv = 20'(999990 + $urandom % 20);
                2: rv = 20'($urandom % 100);
                default: rv = 20'($urandom % 10000);
            endcase
            load_a(rv, 1'($urandom), 1'($urandom), 0, acc5);
            if ($urandom % 3 == 0) drain();
        end
        drain();
        for (int i = 0; i < 30; i++) begin
            load_b(7'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom % 2 == 0) drain();
        end
        drain();

        nd0 = ndone_a;
        load_a(20'd777777, 0, 0, 0, accr);
        while (cyc < accr + 9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_hex", 64'(hexa), 64'({6{7'b1111111}}));
        chk("mid_rst_ready", 64'(ifa.in_ready), 64'(1));
        chk("mid_rst_done", 64'(donea), 64'(0));
        chk("mid_rst_ovf", 64'(ovfa), 64'(0));
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_no_done", 64'(ndone_a - nd0), 64'(0));

        load_a(20'd31415, 0, 1, 0, acc5); drain();
        chk("post_rst_q", 64'(qa.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
